// File: rtl/core_fpu_dispatch.sv
// core_fpu_dispatch: issues one op to a one-hot selected FP core over AXI-Stream channels and retires its result.
// Optional FPU_TIMEOUT_EN adds an ISSUE/WAIT watchdog that forces an all-ones error retire.
module core_fpu_dispatch #(
    parameter int DATA_W = 32,
    parameter int N_UNITS = 7,
    parameter int OP_W = 8,
    parameter logic [N_UNITS-1:0] USES_B = 7'b0001111,
    parameter logic [N_UNITS-1:0] USES_OP = 7'b0001001,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      i_valid,
    input  logic [N_UNITS-1:0]        i_unit,
    input  logic [OP_W-1:0]           i_op,
    input  logic [DATA_W-1:0]         i_a,
    input  logic [DATA_W-1:0]         i_b,
    output logic [DATA_W-1:0]         fpu_result,
    output logic                      fpu_done,
    output logic                      fpu_err,
    output logic                      fpu_stole,
    output logic [N_UNITS*DATA_W-1:0] u_a_tdata,
    output logic [N_UNITS-1:0]        u_a_tvalid,
    input  logic [N_UNITS-1:0]        u_a_tready,
    output logic [N_UNITS*DATA_W-1:0] u_b_tdata,
    output logic [N_UNITS-1:0]        u_b_tvalid,
    input  logic [N_UNITS-1:0]        u_b_tready,
    output logic [N_UNITS*OP_W-1:0]   u_op_tdata,
    output logic [N_UNITS-1:0]        u_op_tvalid,
    input  logic [N_UNITS-1:0]        u_op_tready,
    input  logic [N_UNITS*DATA_W-1:0] u_r_tdata,
    input  logic [N_UNITS-1:0]        u_r_tvalid,
    output logic [N_UNITS-1:0]        u_r_tready
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [N_UNITS-1:0] unit_q, unit_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d, r_sel;
    logic [OP_W-1:0] op_q, op_d;
    logic pa_q, pa_d, pb_q, pb_d, po_q, po_d, got_q, got_d, err_q, err_d;
    logic legal, issue, waiting, acc_a, acc_b, acc_o, r_hit;
`ifdef FPU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYC != 0;
`endif
    assign legal = i_unit != '0 && (i_unit & (i_unit - N_UNITS'(1))) == '0;
    assign issue = state_q == ISSUE;
    assign waiting = state_q == WAIT;
    assign acc_a = |(u_a_tvalid & u_a_tready);
    assign acc_b = |(u_b_tvalid & u_b_tready);
    assign acc_o = |(u_op_tvalid & u_op_tready);
    assign r_hit = |(u_r_tvalid & u_r_tready);
    assign u_r_tready = (issue || waiting) ? unit_q : '0;
    assign fpu_stole = issue || waiting || (state_q == IDLE && i_valid);
    assign fpu_done = state_q == DONE;
    assign fpu_err = err_q;
    assign fpu_result = result_q;
    always_comb begin
        u_a_tvalid = '0;
        u_b_tvalid = '0;
        u_op_tvalid = '0;
        u_a_tdata = '0;
        u_b_tdata = '0;
        u_op_tdata = '0;
        r_sel = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            u_a_tvalid[u] = issue && pa_q && unit_q[u];
            u_b_tvalid[u] = issue && pb_q && unit_q[u];
            u_op_tvalid[u] = issue && po_q && unit_q[u];
            u_a_tdata[u*DATA_W +: DATA_W] = (issue && pa_q && unit_q[u]) ? a_q : '0;
            u_b_tdata[u*DATA_W +: DATA_W] = (issue && pb_q && unit_q[u]) ? b_q : '0;
            u_op_tdata[u*OP_W +: OP_W] = (issue && po_q && unit_q[u]) ? op_q : '0;
            r_sel = r_sel | (unit_q[u] ? u_r_tdata[u*DATA_W +: DATA_W] : '0);
        end
    end
    always_comb begin
        state_d = state_q;
        unit_d = unit_q;
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        pa_d = pa_q;
        pb_d = pb_q;
        po_d = po_q;
        got_d = got_q;
        result_d = result_q;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (i_valid) begin
                if (legal) begin
                    state_d = ISSUE;
                    unit_d = i_unit;
                    a_d = i_a;
                    b_d = i_b;
                    op_d = i_op;
                    pa_d = 1'b1;
                    pb_d = |(i_unit & USES_B);
                    po_d = |(i_unit & USES_OP);
                    got_d = 1'b0;
                end else
                    err_d = 1'b1;
            end
            ISSUE: begin
                pa_d = pa_q && !acc_a;
                pb_d = pb_q && !acc_b;
                po_d = po_q && !acc_o;
                if (r_hit && !got_q) begin
                    result_d = r_sel;
                    got_d = 1'b1;
                end
                if (!pa_d && !pb_d && !po_d) state_d = WAIT;
            end
            WAIT: if (got_q) state_d = DONE;
            else if (r_hit) begin
                result_d = r_sel;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
`ifdef FPU_TIMEOUT_EN
        // The count restarts on every state change, so ISSUE and WAIT each get a full budget.
        cnt_d = ((issue || waiting) && state_d == state_q) ? cnt_q + CW'(1) : '0;
        if ((issue || waiting) && state_d == state_q && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_d = DONE;
            result_d = '1;
            err_d = 1'b1;
        end
`endif
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            unit_q <= '0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            pa_q <= 1'b0;
            pb_q <= 1'b0;
            po_q <= 1'b0;
            got_q <= 1'b0;
            result_q <= '0;
            err_q <= 1'b0;
`ifdef FPU_TIMEOUT_EN
            cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            unit_q <= unit_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            pa_q <= pa_d;
            pb_q <= pb_d;
            po_q <= po_d;
            got_q <= got_d;
            result_q <= result_d;
            err_q <= err_d;
`ifdef FPU_TIMEOUT_EN
            cnt_q <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_core_fpu_dispatch.sv
// tb_core_fpu_dispatch: directed and randomized transactions checked against a cycle-count model of the dispatcher.
module tb_core_fpu_dispatch;
    localparam int DW = 32;
    localparam int N = 7;
    localparam int OW = 8;
    localparam logic [N-1:0] UB = 7'b0001111;
    localparam logic [N-1:0] UO = 7'b0001001;
    logic CLK = 1'b0, RST = 1'b1, i_valid = 1'b0;
    logic [N-1:0] i_unit = '0;
    logic [OW-1:0] i_op = '0;
    logic [DW-1:0] i_a = '0, i_b = '0, fpu_result;
    logic fpu_done, fpu_err, fpu_stole;
    logic [N*DW-1:0] u_a_tdata, u_b_tdata, u_r_tdata = '0;
    logic [N*OW-1:0] u_op_tdata;
    logic [N-1:0] u_a_tvalid, u_b_tvalid, u_op_tvalid, u_r_tready;
    logic [N-1:0] u_a_tready = '0, u_b_tready = '0, u_op_tready = '0, u_r_tvalid = '0;
    int checks = 0, errors = 0;
    core_fpu_dispatch #(.TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST(RST), .i_valid(i_valid), .i_unit(i_unit), .i_op(i_op), .i_a(i_a), .i_b(i_b),
        .fpu_result(fpu_result), .fpu_done(fpu_done), .fpu_err(fpu_err), .fpu_stole(fpu_stole),
        .u_a_tdata(u_a_tdata), .u_a_tvalid(u_a_tvalid), .u_a_tready(u_a_tready),
        .u_b_tdata(u_b_tdata), .u_b_tvalid(u_b_tvalid), .u_b_tready(u_b_tready),
        .u_op_tdata(u_op_tdata), .u_op_tvalid(u_op_tvalid), .u_op_tready(u_op_tready),
        .u_r_tdata(u_r_tdata), .u_r_tvalid(u_r_tvalid), .u_r_tready(u_r_tready)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic noise();
        u_a_tready = N'($urandom);
        u_b_tready = N'($urandom);
        u_op_tready = N'($urandom);
        u_r_tvalid = N'($urandom);
        for (int k = 0; k < N; k++) u_r_tdata[k*DW +: DW] = $urandom;
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_a_tvalid"}, u_a_tvalid, 0);
        chk({tag, "_b_tvalid"}, u_b_tvalid, 0);
        chk({tag, "_op_tvalid"}, u_op_tvalid, 0);
        chk({tag, "_r_tready"}, u_r_tready, 0);
        chk({tag, "_a_tdata"}, u_a_tdata, 0);
    endtask
    // Model: a channel with ready delay d is valid for cycles 1..d+1; the op retires one cycle
    // after both all inputs are accepted (WAIT reached) and the result has been taken.
    task automatic run_op(input int u, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op,
                          input int da, input int db, input int dop, input int dr, input logic [DW-1:0] res,
                          input int abort_at);
        logic [N-1:0] oh;
        logic [N*DW-1:0] ea, eb;
        logic [N*OW-1:0] eo;
        int ta, done;
        oh = N'(1) << u;
        ta = da + 1;
        if (UB[u] && db + 1 > ta) ta = db + 1;
        if (UO[u] && dop + 1 > ta) ta = dop + 1;
        done = ((ta + 1 > dr) ? ta + 1 : dr) + 1;
        step();
        RST = 1'b0;
        i_valid = 1'b1; i_unit = oh; i_a = a; i_b = b; i_op = op;
        noise();
        u_r_tvalid = '0;
        @(negedge CLK);
        chk("req_stole", fpu_stole, 1);
        chk("req_a_tvalid", u_a_tvalid, 0);
        for (int t = 1; t <= done; t++) begin
            step();
            i_valid = (t == done) ? 1'b1 : 1'(($urandom) & 1);
            i_unit = (t == done) ? 7'b0000110 : N'($urandom);
            i_a = $urandom; i_b = $urandom; i_op = OW'($urandom);
            noise();
            u_a_tready[u] = t >= da + 1;
            u_b_tready[u] = t >= db + 1;
            u_op_tready[u] = t >= dop + 1;
            u_r_tvalid[u] = t == dr;
            if (t == dr) u_r_tdata[u*DW +: DW] = res;
            RST = t == abort_at;
            ea = '0; eb = '0; eo = '0;
            if (t <= da + 1) ea[u*DW +: DW] = a;
            if (UB[u] && t <= db + 1) eb[u*DW +: DW] = b;
            if (UO[u] && t <= dop + 1) eo[u*OW +: OW] = op;
            @(negedge CLK);
            chk("a_tvalid", u_a_tvalid, (t <= da + 1) ? oh : 0);
            chk("b_tvalid", u_b_tvalid, (UB[u] && t <= db + 1) ? oh : 0);
            chk("op_tvalid", u_op_tvalid, (UO[u] && t <= dop + 1) ? oh : 0);
            chk("a_tdata", u_a_tdata, ea);
            chk("b_tdata", u_b_tdata, eb);
            chk("op_tdata", u_op_tdata, eo);
            chk("r_tready", u_r_tready, (t < done) ? oh : 0);
            chk("stole", fpu_stole, t < done);
            chk("done", fpu_done, t == done);
            if (t == done) begin
                chk("result", fpu_result, res);
                chk("done_err", fpu_err, 0);
            end
            if (t == abort_at) begin
                step();
                RST = 1'b0; i_valid = 1'b0;
                noise();
                @(negedge CLK);
                chk_quiet("rst");
                chk("rst_done", fpu_done, 0);
                chk("rst_err", fpu_err, 0);
                chk("rst_stole", fpu_stole, 0);
                chk("rst_result", fpu_result, 0);
                return;
            end
        end
        step();
        i_valid = 1'b0;
        noise();
        @(negedge CLK);
        chk("done_req_ignored_err", fpu_err, 0);
        chk_quiet("post_done");
        chk("post_done_stole", fpu_stole, 0);
        chk("result_hold", fpu_result, res);
    endtask
    task automatic illegal(input logic [N-1:0] sel);
        step();
        i_valid = 1'b1; i_unit = sel; i_a = $urandom;
        noise();
        @(negedge CLK);
        chk("ill_stole", fpu_stole, 1);
        step();
        i_valid = 1'b0;
        @(negedge CLK);
        chk("ill_err", fpu_err, 1);
        chk_quiet("ill");
        chk("ill_idle_stole", fpu_stole, 0);
        step();
        @(negedge CLK);
        chk("ill_err_pulse", fpu_err, 0);
    endtask
    initial begin
        logic [N-1:0] bad;
        int u, dr;
        repeat (3) step();
        @(negedge CLK);
        chk_quiet("reset");
        chk("reset_result", fpu_result, 0);
        chk("reset_done", fpu_done, 0);
        chk("reset_err", fpu_err, 0);
        chk("reset_b_tdata", u_b_tdata, 0);
        chk("reset_op_tdata", u_op_tdata, 0);
        run_op(0, 32'h3F800000, 32'h40000000, 8'h01, 0, 0, 0, 3, 32'h40400000, 0);
        run_op(1, 32'h11111111, 32'h22222222, 8'h02, 4, 0, 0, 2, 32'h33333333, 0);
        run_op(4, 32'h00000005, 32'hDEADBEEF, 8'h07, 0, 0, 0, 2, 32'h40A00000, 0);
        illegal(7'b0000110);
        illegal(7'b0000000);
        run_op(2, 32'hAAAA0000, 32'h0000BBBB, 8'h03, 0, 0, 0, 1000, 32'h12345678, 4);
        run_op(3, 32'hCAFEF00D, 32'h0BADF00D, 8'h5A, 1, 2, 3, 1, 32'h87654321, 0);
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do bad = N'($urandom); while (bad != 0 && $countones(bad) == 1);
                illegal(bad);
            end else begin
                u = $urandom_range(0, N - 1);
                dr = $urandom_range(1, 9);
                run_op(u, $urandom, $urandom, OW'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(0, 4), dr, $urandom, 0);
            end
        end
`ifdef FPU_TIMEOUT_EN
        step();
        i_valid = 1'b1; i_unit = 7'b0000001; i_a = 32'h1; i_b = 32'h2;
        u_a_tready = '1; u_b_tready = '1; u_op_tready = '1; u_r_tvalid = '0;
        step();
        i_valid = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            @(negedge CLK);
            chk("to_done", fpu_done, t == 17);
            chk("to_err", fpu_err, t == 17);
            if (t == 17) chk("to_result", fpu_result, 32'hFFFFFFFF);
            step();
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
